// File: rtl/neuron_pkg.sv
// Shared types and helpers for the LIF neuron block.
// State encoding, reset-mode constants, saturating add.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIRE  = 2'd2
  } state_e;

  localparam int RESET_TO_VALUE = 0;
  localparam int RESET_SUBTRACT = 1;

  // Signed add clamped to a w-bit range; operands are
  // sign-extended 32-bit values, sum formed at 33 bits.
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int                 w
  );
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a} + {b[31], b};
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -hi - 33'sd1;
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return s[31:0];
  endfunction

endpackage

// File: rtl/neuron_block_seq_if.sv
// Axon-beat / result bundle of the LIF neuron.
// Master drives beats and config, slave returns results.
interface neuron_block_seq_if #(
  parameter int DATA_W      = 8,
  parameter int NUM_WEIGHTS = 4,
  parameter int WSEL_W      = 2
);

  logic                          enable_i;
  logic                          start_i;
  logic                          valid_i;
  logic                          last_i;
  logic                          axon_spike_i;
  logic [WSEL_W-1:0]             weight_select_i;
  logic [NUM_WEIGHTS*DATA_W-1:0] weights_i;
  logic signed [DATA_W-1:0]      voltage_potential_i;
  logic signed [DATA_W-1:0]      pos_threshold_i;
  logic signed [DATA_W-1:0]      neg_threshold_i;
  logic signed [DATA_W-1:0]      leak_value_i;
  logic signed [DATA_W-1:0]      pos_reset_i;
  logic signed [DATA_W-1:0]      neg_reset_i;
  logic                          ready_o;
  logic                          done_o;
  logic                          spike_o;
  logic signed [DATA_W-1:0]      new_potential_o;

  modport master (
    output enable_i, start_i, valid_i, last_i,
    output axon_spike_i, weight_select_i, weights_i,
    output voltage_potential_i, pos_threshold_i,
    output neg_threshold_i, leak_value_i,
    output pos_reset_i, neg_reset_i,
    input  ready_o, done_o, spike_o, new_potential_o
  );

  modport slave (
    input  enable_i, start_i, valid_i, last_i,
    input  axon_spike_i, weight_select_i, weights_i,
    input  voltage_potential_i, pos_threshold_i,
    input  neg_threshold_i, leak_value_i,
    input  pos_reset_i, neg_reset_i,
    output ready_o, done_o, spike_o, new_potential_o
  );

endinterface

// File: rtl/neuron_sat_adder.sv
// Parametrised signed saturating adder.
// Result clamped to the W-bit signed range.
module neuron_sat_adder
  import neuron_pkg::*;
#(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum
);

  logic signed [31:0] full;
  logic               unused_hi;

  assign full      = sat_add(32'(a), 32'(b), W);
  assign sum       = full[W-1:0];
  assign unused_hi = ^full[31:W];

endmodule

// File: rtl/neuron_block_seq.sv
// Sequential leaky integrate-and-fire neuron.
// Accumulates weighted axon beats, fires on last beat.
module neuron_block_seq
  import neuron_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_WEIGHTS = 4,
  parameter int WSEL_W      = 2,
  parameter int RESET_MODE  = 0
) (
  input logic               clk_i,
  input logic               rst_ni,
  neuron_block_seq_if.slave bus
);

  state_e state_q, state_d;

  logic signed [DATA_W-1:0] acc_q;
  logic signed [DATA_W-1:0] base;
  logic signed [DATA_W-1:0] w;
  logic signed [DATA_W-1:0] sum_w;
  logic signed [DATA_W-1:0] v;
  logic signed [DATA_W-1:0] v_sub;
  logic signed [DATA_W-1:0] res_v;
  logic signed [DATA_W-1:0] pot_q;
  logic signed [31:0]       sub_full;
  logic                     unused_sub;
  logic en_q, en_eff, load, accept, fire;
  logic res_spk, spike_q;

  // start loads the stored potential; ignored in FIRE
  assign load   = bus.start_i & (state_q != FIRE);
  assign accept = bus.valid_i & (state_q != FIRE)
                & (load | (state_q == ACCUM));
  assign fire   = accept & bus.last_i;
  assign base   = load ? bus.voltage_potential_i : acc_q;
  assign en_eff = load ? bus.enable_i : en_q;

  // select this beat's weight, zero if no spike or bad index
  always_comb begin
    w = '0;
    for (int k = 0; k < NUM_WEIGHTS; k++) begin
      if (bus.axon_spike_i & en_eff
          & (int'(bus.weight_select_i) == k)) begin
        w = bus.weights_i[k*DATA_W +: DATA_W];
      end
    end
  end

  neuron_sat_adder #(.W(DATA_W)) u_wadd (
    .a   (base),
    .b   (w),
    .sum (sum_w)
  );

  neuron_sat_adder #(.W(DATA_W)) u_leak (
    .a   (sum_w),
    .b   (bus.leak_value_i),
    .sum (v)
  );

  assign sub_full = sat_add(32'(v),
                            -32'(bus.pos_threshold_i),
                            DATA_W);
  assign v_sub      = sub_full[DATA_W-1:0];
  assign unused_sub = ^sub_full[31:DATA_W];

  // threshold / reset rule, disabled neuron forces zero
  always_comb begin
    res_spk = 1'b0;
    res_v   = v;
    if (!en_eff) begin
      res_v = '0;
    end else if (v >= bus.pos_threshold_i) begin
      res_spk = 1'b1;
      res_v   = (RESET_MODE == RESET_SUBTRACT)
              ? v_sub : bus.pos_reset_i;
    end else if (v < bus.neg_threshold_i) begin
      res_v = bus.neg_reset_i;
    end
  end

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // next state: FIRE lasts one cycle
  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      (state_q == FIRE): state_d = IDLE;
      fire:              state_d = FIRE;
      load:              state_d = ACCUM;
      default:           state_d = state_q;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    bus.ready_o = (state_q != FIRE);
    bus.done_o  = (state_q == FIRE);
  end

  // accumulator and sampled enable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      en_q  <= 1'b0;
    end else begin
      if (load)            en_q  <= bus.enable_i;
      if (accept)          acc_q <= sum_w;
      else if (load)       acc_q <= base;
    end
  end

  // result registers, held until the next fire
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spike_q <= 1'b0;
      pot_q   <= '0;
    end else if (fire) begin
      spike_q <= res_spk;
      pot_q   <= res_v;
    end
  end

  assign bus.spike_o         = spike_q;
  assign bus.new_potential_o = pot_q;

endmodule

// File: tb/tb_neuron_block_seq.sv
// Directed bench for neuron_block_seq.
// Three DUTs: subtract-reset, value-reset, three weights.
module tb_neuron_block_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic en, start, valid, last, spk;
  logic [1:0] sel;
  logic signed [7:0] w0, w1, w2, w3;
  logic signed [7:0] pot, pth, nth, leak, prst, nrst;

  int checks = 0;
  int errors = 0;

  neuron_block_seq_if #(.DATA_W(8), .NUM_WEIGHTS(4), .WSEL_W(2)) if0 ();
  neuron_block_seq_if #(.DATA_W(8), .NUM_WEIGHTS(4), .WSEL_W(2)) if1 ();
  neuron_block_seq_if #(.DATA_W(8), .NUM_WEIGHTS(3), .WSEL_W(2)) if2 ();

`define NB_DRIVE(I) \
  assign I.enable_i = en; \
  assign I.start_i = start; \
  assign I.valid_i = valid; \
  assign I.last_i = last; \
  assign I.axon_spike_i = spk; \
  assign I.weight_select_i = sel; \
  assign I.voltage_potential_i = pot; \
  assign I.pos_threshold_i = pth; \
  assign I.neg_threshold_i = nth; \
  assign I.leak_value_i = leak; \
  assign I.pos_reset_i = prst; \
  assign I.neg_reset_i = nrst;

  `NB_DRIVE(if0)
  `NB_DRIVE(if1)
  `NB_DRIVE(if2)

  assign if0.weights_i = {w3, w2, w1, w0};
  assign if1.weights_i = {w3, w2, w1, w0};
  assign if2.weights_i = {w2, w1, w0};

  neuron_block_seq #(
    .DATA_W(8), .NUM_WEIGHTS(4), .WSEL_W(2), .RESET_MODE(0)
  ) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0));

  neuron_block_seq #(
    .DATA_W(8), .NUM_WEIGHTS(4), .WSEL_W(2), .RESET_MODE(1)
  ) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));

  neuron_block_seq #(
    .DATA_W(8), .NUM_WEIGHTS(3), .WSEL_W(2), .RESET_MODE(0)
  ) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    en = 1; start = 0; valid = 0; last = 0; spk = 0; sel = 0;
    w0 = 7; w1 = 5; w2 = 0; w3 = -2;
    pot = 10; pth = 30; nth = -100; leak = -1;
    prst = 0; nrst = -10;

    #3;
    chk("rst_ready", 32'(if0.ready_o), 1);
    chk("rst_done", 32'(if0.done_o), 0);
    chk("rst_spike", 32'(if0.spike_o), 0);
    chk("rst_pot", if0.new_potential_o, 0);
    tick; tick;
    rst_n = 1;
    tick;

    // basic accumulate with leak
    start = 1; tick;
    start = 0; valid = 1; spk = 1; sel = 1; tick;
    chk("t1_nodone", 32'(if0.done_o), 0);
    sel = 3; tick;
    sel = 0; last = 1; tick;
    chk("t1_done", 32'(if0.done_o), 1);
    chk("t1_ready", 32'(if0.ready_o), 0);
    chk("t1_spike", 32'(if0.spike_o), 0);
    chk("t1_pot", if0.new_potential_o, 19);
    chk("t1_pot_nw3", if2.new_potential_o, 21);

    // beat and start offered during FIRE are ignored
    start = 1; valid = 1; last = 1; pot = 50; tick;
    start = 0; valid = 0; last = 0;
    chk("t6_fire_done", 32'(if0.done_o), 0);
    chk("t6_fire_pot", if0.new_potential_o, 19);
    tick;
    chk("t6_fire_nodone", 32'(if0.done_o), 0);

    // positive saturation, both reset modes
    pot = 100; pth = 120; prst = 0; leak = 0; w0 = 50;
    start = 1; tick;
    start = 0; valid = 1; last = 1; spk = 1; sel = 0; tick;
    valid = 0; last = 0;
    chk("t2_done", 32'(if0.done_o), 1);
    chk("t2_spike_m0", 32'(if0.spike_o), 1);
    chk("t2_pot_m0", if0.new_potential_o, 0);
    chk("t2_spike_m1", 32'(if1.spike_o), 1);
    chk("t2_pot_m1", if1.new_potential_o, 7);
    tick;

    // negative saturation and negative reset
    pot = -120; w1 = -20; leak = -5; pth = 30;
    nth = -100; nrst = -10;
    start = 1; tick;
    start = 0; valid = 1; spk = 1; sel = 1; tick;
    spk = 0; last = 1; tick;
    valid = 0; last = 0;
    chk("t3_done", 32'(if0.done_o), 1);
    chk("t3_spike", 32'(if0.spike_o), 0);
    chk("t3_pot", if0.new_potential_o, -10);
    tick;

    // restart abandons a packet in progress
    leak = 0; w0 = 7; w2 = 1; w3 = 2; pot = 10;
    start = 1; tick;
    start = 0; valid = 1; spk = 1; sel = 0; tick; tick;
    chk("t4_nodone_a", 32'(if0.done_o), 0);
    valid = 0; pot = 3; start = 1; tick;
    start = 0;
    chk("t4_nodone_b", 32'(if0.done_o), 0);
    valid = 1; last = 1; sel = 2; tick;
    valid = 0; last = 0;
    chk("t4_done", 32'(if0.done_o), 1);
    chk("t4_pot", if0.new_potential_o, 4);
    tick;
    chk("t4_one_done", 32'(if0.done_o), 0);

    // start, beat and last in one cycle
    pot = 3; sel = 3; spk = 1;
    start = 1; valid = 1; last = 1; tick;
    start = 0; valid = 0; last = 0;
    chk("t4b_done", 32'(if0.done_o), 1);
    chk("t4b_pot", if0.new_potential_o, 5);
    chk("t6_sel3_nw3", if2.new_potential_o, 3);
    tick;

    // threshold equality fires
    pot = 30; pth = 30; prst = -3; leak = 0;
    start = 1; tick;
    start = 0; valid = 1; last = 1; spk = 0; tick;
    valid = 0; last = 0;
    chk("t7_spike_m0", 32'(if0.spike_o), 1);
    chk("t7_pot_m0", if0.new_potential_o, -3);
    chk("t7_pot_m1", if1.new_potential_o, 0);
    tick;

    // reset in the middle of a packet
    pot = 10; start = 1; tick;
    start = 0; valid = 1; spk = 1; sel = 0; tick;
    valid = 0;
    #1 rst_n = 0;
    #1;
    chk("t5_rst_pot", if0.new_potential_o, 0);
    chk("t5_rst_spike", 32'(if0.spike_o), 0);
    chk("t5_rst_ready", 32'(if0.ready_o), 1);
    chk("t5_rst_done", 32'(if0.done_o), 0);
    valid = 1; last = 1; tick;
    rst_n = 1;
    tick;
    chk("t5_dropped", 32'(if0.done_o), 0);
    valid = 0; last = 0; tick;
    chk("t5_no_done", 32'(if0.done_o), 0);

    // negative threshold equality leaves v unchanged
    pot = -100; nth = -100;
    start = 1; tick;
    start = 0; valid = 1; last = 1; spk = 0; tick;
    valid = 0; last = 0;
    chk("t8_spike", 32'(if0.spike_o), 0);
    chk("t8_pot", if0.new_potential_o, -100);
    tick;

    // disabled neuron returns zero with no spike
    en = 0; pot = 50; w0 = 7; pth = 30;
    start = 1; tick;
    start = 0; en = 1; valid = 1; spk = 1; sel = 0; tick;
    last = 1; tick;
    valid = 0; last = 0;
    chk("t5_dis_done", 32'(if0.done_o), 1);
    chk("t5_dis_spike", 32'(if0.spike_o), 0);
    chk("t5_dis_pot", if0.new_potential_o, 0);
    chk("t5_dis_spike_m1", 32'(if1.spike_o), 0);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
